matrix_3x3_gen: RTL

Upstream neighbour of the 3x3 median stage: turns a raster 8-bit pixel stream into a 3x3 neighbourhood window (`matrix11`..`matrix33`) plus `matrix_de`, one window per input pixel. Two internal line buffers hold the previous two lines. Out-of-image positions above and to the left are zero-padded, so the downstream filter sees a defined window for every pixel.

---
 rtl/matrix_3x3_gen_pkg.sv | 14 +
 rtl/matrix_3x3_gen_line_buffer_ram.sv | 29 ++
 rtl/matrix_3x3_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/matrix_3x3_gen_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
package matrix_3x3_gen_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 3;

    typedef logic [PIX_W-1:0] pix_t;

    // Pass a tap through, or force it to zero for out-of-image positions.
    function automatic pix_t tap_mask(input pix_t d, input logic keep);
        return keep ? d : '0;
    endfunction

endpackage

// File: rtl/matrix_3x3_gen_line_buffer_ram.sv
// Simple dual-port line buffer with registered read (block-RAM friendly).
module line_buffer_ram
    import matrix_3x3_gen_pkg::*;
#(
    parameter int unsigned Depth = 640,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  pix_t             wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output pix_t             rdata_o
);

    pix_t mem_q [Depth];
    pix_t rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_3x3_gen.sv
// Raster pixel stream to 3x3 zero-padded neighbourhood window, 2-cycle latency.
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_vsync,
    input  logic             pix_de,
    input  logic [PIX_W-1:0] pix_data,
    output logic             matrix_de,
    output logic [PIX_W-1:0] matrix11,
    output logic [PIX_W-1:0] matrix12,
    output logic [PIX_W-1:0] matrix13,
    output logic [PIX_W-1:0] matrix21,
    output logic [PIX_W-1:0] matrix22,
    output logic [PIX_W-1:0] matrix23,
    output logic [PIX_W-1:0] matrix31,
    output logic [PIX_W-1:0] matrix32,
    output logic [PIX_W-1:0] matrix33
);

    localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(IMG_WIDTH - 1);

    logic              vs_q;
    logic              de_d1_q, de_d2_q;
    logic [ADDR_W-1:0] col_q, col_d, col_d1_q;
    logic [1:0]        rows_q, rows_d, rows_d1_q;
    logic              disc_q, disc_d;
    pix_t              pix_q;
    pix_t              buf1_rd, buf2_rd;
    pix_t              row_new [WIN_W];
    pix_t              win_q [WIN_W][WIN_W];
    logic              line_end, frame_start;

    assign line_end    = de_d1_q & ~pix_de;
    assign frame_start = pix_vsync & ~vs_q;

    // Column / line counters; a vsync edge overrides a coincident line end.
    always_comb begin
        col_d  = col_q;
        rows_d = rows_q;
        disc_d = disc_q;
        if (pix_de && (col_q != ColMax)) begin
            col_d = col_q + 1'b1;
        end
        if (line_end) begin
            col_d  = '0;
            disc_d = 1'b0;
            // A line cut by vsync does not count as a completed line.
            if (!disc_q && (rows_q != 2'd2)) begin
                rows_d = rows_q + 2'd1;
            end
        end
        if (frame_start) begin
            col_d  = '0;
            rows_d = '0;
            disc_d = pix_de;
        end
    end

    // Counter state, input sample stage and DE delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            de_d1_q   <= 1'b0;
            de_d2_q   <= 1'b0;
            col_q     <= '0;
            col_d1_q  <= '0;
            rows_q    <= '0;
            rows_d1_q <= '0;
            disc_q    <= 1'b0;
            pix_q     <= '0;
        end else begin
            vs_q      <= pix_vsync;
            de_d1_q   <= pix_de;
            de_d2_q   <= de_d1_q;
            col_q     <= col_d;
            col_d1_q  <= col_q;
            rows_q    <= rows_d;
            rows_d1_q <= rows_q;
            disc_q    <= disc_d;
            pix_q     <= pix_data;
        end
    end

    // buf1 holds row r-1; its displaced contents cascade into buf2 (row r-2).
    line_buffer_ram #(
        .Depth (IMG_WIDTH),
        .AddrW (ADDR_W)
    ) u_buf1 (
        .clk_i   (clk),
        .we_i    (de_d1_q),
        .waddr_i (col_d1_q),
        .wdata_i (pix_q),
        .raddr_i (col_q),
        .rdata_o (buf1_rd)
    );

    line_buffer_ram #(
        .Depth (IMG_WIDTH),
        .AddrW (ADDR_W)
    ) u_buf2 (
        .clk_i   (clk),
        .we_i    (de_d1_q),
        .waddr_i (col_d1_q),
        .wdata_i (buf1_rd),
        .raddr_i (col_q),
        .rdata_o (buf2_rd)
    );

    // New column-c taps, masked while the frame has too few completed lines.
    always_comb begin
        row_new[0] = tap_mask(buf2_rd, rows_d1_q >= 2'd2);
        row_new[1] = tap_mask(buf1_rd, rows_d1_q >= 2'd1);
        row_new[2] = pix_q;
    end

    // Shift window left and load column c; left padding at line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN_W; r++) begin
                for (int c = 0; c < WIN_W; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (de_d1_q) begin
            for (int r = 0; r < WIN_W; r++) begin
                win_q[r][0] <= tap_mask(win_q[r][1], col_d1_q > ADDR_W'(1));
                win_q[r][1] <= tap_mask(win_q[r][2], col_d1_q != '0);
                win_q[r][2] <= row_new[r];
            end
        end
    end

    assign matrix_de = de_d2_q;
    assign matrix11  = win_q[0][0];
    assign matrix12  = win_q[0][1];
    assign matrix13  = win_q[0][2];
    assign matrix21  = win_q[1][0];
    assign matrix22  = win_q[1][1];
    assign matrix23  = win_q[1][2];
    assign matrix31  = win_q[2][0];
    assign matrix32  = win_q[2][1];
    assign matrix33  = win_q[2][2];

endmodule
